// File: rtl/negator_pkg.sv
// Shared definitions for the negator family: default lane geometry and the
// two's-complement negate helper used by every negator variant.
package negator_pkg;

  localparam int DEFAULT_INTEGER_WIDTH = 32;
  localparam int DEFAULT_NUM_LANES     = 1;

  // Widest lane the shared helper supports; narrower lanes truncate the result,
  // which is exact because low result bits depend only on low operand bits.
  localparam int NEG_MAX_W = 128;

  function automatic logic [NEG_MAX_W-1:0] negate(input logic [NEG_MAX_W-1:0] x);
    return ~x + NEG_MAX_W'(1);
  endfunction

endpackage

// File: rtl/negator_lane.sv
// One combinational lane: y = (~x + 1) mod 2^W.
module negator_lane
  import negator_pkg::*;
#(
  parameter int W = DEFAULT_INTEGER_WIDTH
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = W'(negate(NEG_MAX_W'(x)));

endmodule

// File: rtl/single_cycle_tightly_coupled_negator.sv
// N independent two's-complement negators feeding one output register:
// result appears exactly one cycle after the input is sampled.
module single_cycle_tightly_coupled_negator
  import negator_pkg::*;
#(
  parameter  int WIDTH_IN_NUM_OF_FULL_INTEGER = DEFAULT_NUM_LANES,
  parameter  int INTEGER_WIDTH                = DEFAULT_INTEGER_WIDTH,
  localparam int DATA_WIDTH                   = WIDTH_IN_NUM_OF_FULL_INTEGER * INTEGER_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [DATA_WIDTH-1:0] output_data
);

  localparam int N = WIDTH_IN_NUM_OF_FULL_INTEGER;
  localparam int W = INTEGER_WIDTH;

  logic [N-1:0][W-1:0] lanes_in;
  logic [N-1:0][W-1:0] lanes_neg;

  assign lanes_in = input_data;

  // Each lane negates in isolation, so no carry crosses a lane boundary.
  for (genvar i = 0; i < N; i++) begin : g_lane
    negator_lane #(.W(W)) u_lane (
      .x(lanes_in[i]),
      .y(lanes_neg[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) output_data <= '0;
    else       output_data <= lanes_neg;
  end

endmodule

// File: tb/tb_single_cycle_tightly_coupled_negator.sv
// Directed plus randomized check of the negator, single-lane and two-lane builds,
// against an arithmetic reference (result = 0 - input, per lane, one cycle later).
module tb_single_cycle_tightly_coupled_negator;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in1;
  logic [31:0] out1;
  logic [63:0] in2;
  logic [63:0] out2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp1;
  logic [63:0] exp2;
  bit          known = 1'b0;

  always #5 clock = ~clock;

  single_cycle_tightly_coupled_negator #(
    .WIDTH_IN_NUM_OF_FULL_INTEGER(1),
    .INTEGER_WIDTH(32)
  ) dut1 (
    .clock(clock),
    .reset(reset),
    .input_data(in1),
    .output_data(out1)
  );

  single_cycle_tightly_coupled_negator #(
    .WIDTH_IN_NUM_OF_FULL_INTEGER(2),
    .INTEGER_WIDTH(32)
  ) dut2 (
    .clock(clock),
    .reset(reset),
    .input_data(in2),
    .output_data(out2)
  );

  function automatic logic [31:0] ref_neg(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  function automatic logic [63:0] ref_neg2(input logic [63:0] v);
    logic [63:0] r;
    r[31:0]  = ref_neg(v[31:0]);
    r[63:32] = ref_neg(v[63:32]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one vector between edges, confirm the output has not moved yet,
  // then clock it and compare against the reference.
  task automatic step(input string tag, input logic rst, input logic [31:0] a, input logic [63:0] b);
    reset = rst;
    in1   = a;
    in2   = b;
    #1;
    if (known) begin
      check({tag, "_hold1"}, {32'd0, out1}, {32'd0, exp1});
      check({tag, "_hold2"}, out2, exp2);
    end
    @(posedge clock);
    #1;
    exp1  = rst ? 32'd0 : ref_neg(a);
    exp2  = rst ? 64'd0 : ref_neg2(b);
    known = 1'b1;
    check(tag, {32'd0, out1}, {32'd0, exp1});
    check({tag, "_x2"}, out2, exp2);
    @(negedge clock);
  endtask

  logic [31:0] bnd_in  [4] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [31:0] bnd_out [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001};

  initial begin
    reset = 1'b1;
    in1   = '0;
    in2   = '0;
    @(negedge clock);

    // reset held two cycles with a live input
    step("reset_a", 1'b1, 32'h5, 64'h5);
    step("reset_b", 1'b1, 32'h5, 64'h5);

    // basic
    step("basic", 1'b0, 32'h5, 64'h5);
    check("basic_const", {32'd0, out1}, 64'hFFFF_FFFB);

    // boundaries against fixed answers
    for (int i = 0; i < 4; i++) begin
      step("bound", 1'b0, bnd_in[i], {bnd_in[i], bnd_in[i]});
      check("bound_const", {32'd0, out1}, {32'd0, bnd_out[i]});
    end

    // streaming 1,2,3
    for (int i = 1; i <= 3; i++) begin
      step("stream", 1'b0, i, 64'(i));
      check("stream_const", {32'd0, out1}, {32'd0, 32'(-i)});
    end

    // held input -> held output
    step("held_a", 1'b0, 32'h1234_5678, 64'h0);
    step("held_b", 1'b0, 32'h1234_5678, 64'h0);

    // two lanes, no carry between them
    step("multilane", 1'b0, 32'h0, {32'h0000_0001, 32'h8000_0000});
    check("multilane_const", out2, {32'hFFFF_FFFF, 32'h8000_0000});
    step("multilane_b", 1'b0, 32'h0, {32'h0000_0000, 32'hFFFF_FFFF});
    check("multilane_b_const", out2, {32'h0000_0000, 32'h0000_0001});

    // mid-stream reset pulse
    step("pre_rst", 1'b0, 32'h0000_0009, 64'h7);
    step("mid_rst", 1'b1, 32'h0000_000A, 64'h8);
    check("mid_rst_const", {32'd0, out1}, 64'h0);
    step("post_rst", 1'b0, 32'h0000_000B, 64'h9);
    check("post_rst_const", {32'd0, out1}, 64'hFFFF_FFF5);

    // randomized traffic with occasional resets
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), $urandom, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
